// File: rtl/rle_image_compressor.sv
// rle_image_compressor: run-length encoder for a 1-bit pixel stream.
//   Emits {value, run_length} words through a small output FIFO.
//   Word layout: bit WORD_W-1 = pixel value, bits WORD_W-2:0 = run length (1..2^(WORD_W-1)-1).
// Ports:
//   clk         rising-edge clock
//   RST         synchronous reset, active-low
//   pix_valid   pixel present on pix_in
//   pix_in      pixel value
//   pix_last    final pixel of the image
//   pix_ready   pixel accepted this cycle when pix_valid is high
//   dout        compressed word at the FIFO head (0 when empty)
//   dout_valid  dout holds a word
//   dout_last   dout is the final word of the image
//   dout_ready  consumer takes dout this cycle
//   done        one-cycle pulse after the final word is popped
// Optional build macro RLE_STATS_EN adds:
//   word_count  words pushed for the current image (saturating)
//   pixel_count pixels accepted for the current image
module rle_image_compressor #(
    parameter int WORD_W     = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              pix_valid,
    input  logic              pix_in,
    input  logic              pix_last,
    output logic              pix_ready,
    output logic [WORD_W-1:0] dout,
    output logic              dout_valid,
    output logic              dout_last,
    input  logic              dout_ready,
    output logic              done
`ifdef RLE_STATS_EN
    ,
    output logic [15:0]       word_count,
    output logic [31:0]       pixel_count
`endif
);
    localparam int CW = WORD_W - 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] MAX = '1;
    localparam logic [PW:0] FULL = FIFO_DEPTH[PW:0];

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t            state, state_nx;
    logic              cur_val, cur_val_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic              push, push_last;
    logic [WORD_W-1:0] push_word;
    logic [WORD_W:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       count;
    logic              fifo_full, accept, pop, same, at_max;

    assign fifo_full  = count == FULL;
    assign pix_ready  = RST & ~fifo_full & (state != FLUSH);
    assign accept     = pix_valid & pix_ready;
    assign dout_valid = count != '0;
    assign {dout, dout_last} = dout_valid ? mem[rd_ptr] : '0;
    assign pop        = dout_valid & dout_ready;
    assign same       = pix_in == cur_val;
    assign at_max     = cnt == MAX;

    always_comb begin
        state_nx   = state;
        cur_val_nx = cur_val;
        cnt_nx     = cnt;
        push       = 1'b0;
        push_word  = '0;
        push_last  = 1'b0;
        case (state)
            IDLE: if (accept) begin
                if (pix_last) begin
                    push      = 1'b1;
                    push_word = {pix_in, CW'(1)};
                    push_last = 1'b1;
                end else begin
                    cur_val_nx = pix_in;
                    cnt_nx     = CW'(1);
                    state_nx   = RUN;
                end
            end
            RUN: if (accept) begin
                if (same && !at_max) begin
                    if (pix_last) begin
                        push      = 1'b1;
                        push_word = {cur_val, cnt + CW'(1)};
                        push_last = 1'b1;
                        state_nx  = IDLE;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end else begin
                    // Close the open run; a final pixel that starts a new run needs a second push later.
                    push       = 1'b1;
                    push_word  = {cur_val, cnt};
                    cur_val_nx = pix_in;
                    cnt_nx     = CW'(1);
                    if (pix_last) state_nx = FLUSH;
                end
            end
            FLUSH: if (!fifo_full) begin
                push      = 1'b1;
                push_word = {cur_val, cnt};
                push_last = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!RST) begin
            state   <= IDLE;
            cur_val <= 1'b0;
            cnt     <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            cur_val <= cur_val_nx;
            cnt     <= cnt_nx;
            if (push) begin
                mem[wr_ptr] <= {push_word, push_last};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
            done  <= pop & dout_last;
        end
    end

`ifdef RLE_STATS_EN
    // A pixel accepted while no run is open is the first pixel of a new image.
    always_ff @(posedge clk) begin
        if (!RST) begin
            word_count  <= '0;
            pixel_count <= '0;
        end else if (accept && state == IDLE) begin
            pixel_count <= 32'd1;
            word_count  <= {15'd0, push};
        end else begin
            pixel_count <= pixel_count + {31'd0, accept};
            if (push && word_count != 16'hFFFF) word_count <= word_count + 16'd1;
        end
    end
`endif
endmodule
